// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read bypass, a load-busy scoreboard,
// two debug taps and a wrapping commit-write counter.
module regfile_sb #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter int TAP0_IDX = 2,
  parameter int TAP1_IDX = 3,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    arad,
  input  logic [AW-1:0]    brad,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             a_busy,
  output logic             b_busy,
  input  logic             w0_we,
  input  logic [AW-1:0]    w0_ad,
  input  logic [WIDTH-1:0] w0_d,
  input  logic             w1_we,
  input  logic [AW-1:0]    w1_ad,
  input  logic [WIDTH-1:0] w1_d,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_ad,
  output logic [WIDTH-1:0] tap0,
  output logic [WIDTH-1:0] tap1,
  output logic [15:0]      wcnt
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [15:0]      wcnt_q, wcnt_d;
  logic             w0_ok, w1_ok, iss_ok;
  logic [1:0]       n_wr;

  // Accesses to the hardwired zero register are dropped before anything else sees them.
  assign w0_ok  = w0_we  && !(ZERO_REG && (w0_ad  == '0));
  assign w1_ok  = w1_we  && !(ZERO_REG && (w1_ad  == '0));
  assign iss_ok = iss_en && !(ZERO_REG && (iss_ad == '0));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (w1_ok && (w1_ad == AW'(i)))      regs_d[i] = w1_d;
      else if (w0_ok && (w0_ad == AW'(i))) regs_d[i] = w0_d;
    end
    busy_d = busy_q;
    if (w1_ok)  busy_d[w1_ad]  = 1'b0;
    if (iss_ok) busy_d[iss_ad] = 1'b1;
    n_wr = {1'b0, w0_ok} + {1'b0, w1_ok};
    if (w0_ok && w1_ok && (w0_ad == w1_ad)) n_wr = 2'd1;
    wcnt_d = wcnt_q + {14'd0, n_wr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q <= '0;
      wcnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      busy_q <= busy_d;
      wcnt_q <= wcnt_d;
    end
  end

  function automatic logic [WIDTH-1:0] rd_data(input logic [AW-1:0] rad);
    logic [WIDTH-1:0] v;
    v = regs_q[rad];
    if (BYPASS && w1_we && (w1_ad == rad))      v = w1_d;
    else if (BYPASS && w0_we && (w0_ad == rad)) v = w0_d;
    if (ZERO_REG && (rad == '0))                v = '0;
    return v;
  endfunction

  function automatic logic rd_busy(input logic [AW-1:0] rad);
    return busy_q[rad] && !(BYPASS && w1_we && (w1_ad == rad));
  endfunction

  // Outputs are gated by rst_n so bypassed write data cannot leak out during reset.
  always_comb begin
    a      = '0;
    b      = '0;
    a_busy = 1'b0;
    b_busy = 1'b0;
    if (rst_n) begin
      a      = rd_data(arad);
      b      = rd_data(brad);
      a_busy = rd_busy(arad);
      b_busy = rd_busy(brad);
    end
  end

  assign tap0 = regs_q[TAP0_IDX];
  assign tap1 = regs_q[TAP1_IDX];
  assign wcnt = wcnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing instance and one non-bypassing
// instance share all inputs so forwarding behaviour can be compared side by side.
module tb_regfile_sb;
  localparam int WIDTH = 16;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [AW-1:0]    arad, brad, w0_ad, w1_ad, iss_ad;
  logic [WIDTH-1:0] w0_d, w1_d;
  logic             w0_we, w1_we, iss_en;

  logic [WIDTH-1:0] a0, b0, tap0_0, tap1_0, a1, b1, tap0_1, tap1_1;
  logic             a_busy0, b_busy0, a_busy1, b_busy1;
  logic [15:0]      wcnt0, wcnt1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n), .arad(arad), .brad(brad),
    .a(a0), .b(b0), .a_busy(a_busy0), .b_busy(b_busy0),
    .w0_we(w0_we), .w0_ad(w0_ad), .w0_d(w0_d),
    .w1_we(w1_we), .w1_ad(w1_ad), .w1_d(w1_d),
    .iss_en(iss_en), .iss_ad(iss_ad),
    .tap0(tap0_0), .tap1(tap1_0), .wcnt(wcnt0)
  );

  regfile_sb #(.BYPASS(1'b0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .arad(arad), .brad(brad),
    .a(a1), .b(b1), .a_busy(a_busy1), .b_busy(b_busy1),
    .w0_we(w0_we), .w0_ad(w0_ad), .w0_d(w0_d),
    .w1_we(w1_we), .w1_ad(w1_ad), .w1_d(w1_d),
    .iss_en(iss_en), .iss_ad(iss_ad),
    .tap0(tap0_1), .tap1(tap1_1), .wcnt(wcnt1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w0_we = 1'b0; w1_we = 1'b0; iss_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    arad = '0; brad = '0; w0_ad = '0; w1_ad = '0; iss_ad = '0;
    w0_d = '0; w1_d = '0;
    idle();
    #1;
    chk("rst_a", a0, 0);
    chk("rst_wcnt", wcnt0, 0);
    #11 rst_n = 1'b1;
    tick();

    // async reset mid-run
    w0_we = 1'b1; w0_ad = 3'd2; w0_d = 16'h1234;
    iss_en = 1'b1; iss_ad = 3'd6;
    tick();
    idle();
    arad = 3'd6; brad = 3'd2;
    #1;
    chk("pre_tap0", tap0_0, 16'h1234);
    chk("pre_wcnt", wcnt0, 1);
    chk("pre_abusy", a_busy0, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_tap0", tap0_0, 0);
    chk("rst_b_r2", b0, 0);
    chk("rst_wcnt2", wcnt0, 0);
    chk("rst_abusy", a_busy0, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_b", b0, 0);

    // dual write collision, then distinct addresses
    w0_we = 1'b1; w0_ad = 3'd5; w0_d = 16'hAAAA;
    w1_we = 1'b1; w1_ad = 3'd5; w1_d = 16'h5555;
    tick();
    idle();
    arad = 3'd5;
    #1;
    chk("coll_a", a0, 16'h5555);
    chk("coll_wcnt", wcnt0, 1);
    w0_we = 1'b1; w0_ad = 3'd4; w0_d = 16'h1111;
    w1_we = 1'b1; w1_ad = 3'd5; w1_d = 16'h2222;
    tick();
    idle();
    arad = 3'd4; brad = 3'd5;
    #1;
    chk("dist_a", a0, 16'h1111);
    chk("dist_b", b0, 16'h2222);
    chk("dist_wcnt", wcnt0, 3);

    // w0 bypass vs no bypass
    w0_we = 1'b1; w0_ad = 3'd3; w0_d = 16'h00FF; arad = 3'd3;
    #1;
    chk("byp_a", a0, 16'h00FF);
    chk("nobyp_a", a1, 16'h0000);
    chk("byp_tap1_pre", tap1_0, 16'h0000);
    tick();
    idle();
    #1;
    chk("byp_tap1_post", tap1_0, 16'h00FF);
    chk("nobyp_a_post", a1, 16'h00FF);
    chk("byp_wcnt", wcnt0, 4);

    // scoreboard
    iss_en = 1'b1; iss_ad = 3'd6;
    tick();
    idle();
    arad = 3'd6; brad = 3'd6;
    #1;
    chk("sb_abusy", a_busy0, 1);
    chk("sb_bbusy", b_busy0, 1);
    w1_we = 1'b1; w1_ad = 3'd6; w1_d = 16'h0042;
    #1;
    chk("sb_fwd_busy", a_busy0, 0);
    chk("sb_fwd_a", a0, 16'h0042);
    chk("sb_nofwd_busy", a_busy1, 1);
    chk("sb_nofwd_a", a1, 16'h0000);
    tick();
    idle();
    #1;
    chk("sb_clr_busy", a_busy0, 0);
    chk("sb_clr_busy_nb", a_busy1, 0);
    chk("sb_a", a0, 16'h0042);
    chk("sb_wcnt", wcnt0, 5);
    iss_en = 1'b1; iss_ad = 3'd6;
    w1_we = 1'b1; w1_ad = 3'd6; w1_d = 16'h0077;
    tick();
    idle();
    #1;
    chk("sb_setwin_busy", a_busy0, 1);
    chk("sb_setwin_a", a0, 16'h0077);
    chk("sb_setwin_wcnt", wcnt0, 6);

    // zero register
    w0_we = 1'b1; w0_ad = 3'd0; w0_d = 16'hFFFF;
    iss_en = 1'b1; iss_ad = 3'd0; arad = 3'd0;
    #1;
    chk("z_byp_a", a0, 0);
    tick();
    idle();
    #1;
    chk("z_a", a0, 0);
    chk("z_abusy", a_busy0, 0);
    chk("z_wcnt", wcnt0, 6);

    // counter wrap: 6 + 2*32764 + 1 = 0xFFFF, then one more wraps
    w0_we = 1'b1; w0_ad = 3'd1; w0_d = 16'hBEEF;
    w1_we = 1'b1; w1_ad = 3'd7; w1_d = 16'hCAFE;
    repeat (32764) @(posedge clk);
    #1;
    w1_we = 1'b0;
    tick();
    chk("wrap_ffff", wcnt0, 16'hFFFF);
    tick();
    idle();
    #1;
    chk("wrap_zero", wcnt0, 16'h0000);
    chk("wrap_zero_nb", wcnt1, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
